// File: rtl/fp_addsub_param_if.sv
// fp_addsub_param_if: operand/result handshake bundle for the add/subtract engine.
// W must equal 1+EXP_W+MAN_W of the engine attached to it.
interface fp_addsub_param_if #(
    parameter int W = 32
);
    logic [W-1:0] in_a;
    logic [W-1:0] in_b;
    logic         in_op;
    logic [1:0]   in_rm;
    logic         in_valid;
    logic         in_ready;
    logic [W-1:0] out_data;
    logic [2:0]   out_flags;
    logic         out_valid;
    logic         out_ready;

    modport master (
        output in_a, in_b, in_op, in_rm, in_valid, out_ready,
        input  in_ready, out_data, out_flags, out_valid
    );

    modport slave (
        input  in_a, in_b, in_op, in_rm, in_valid, out_ready,
        output in_ready, out_data, out_flags, out_valid
    );
endinterface

// File: rtl/fp_addsub_param.sv
// fp_addsub_param: parametrised IEEE-754 add/subtract engine with selectable rounding.
// One operation at a time walks a fixed chain of stages, so the result always
// appears 7 cycles after the accept edge regardless of operand class.
module fp_addsub_param #(
    parameter int EXP_W = 8,
    parameter int MAN_W = 23
) (
    input  logic             clk,
    input  logic             rst,
    fp_addsub_param_if.slave bus
);
    localparam int W  = 1 + EXP_W + MAN_W;
    localparam int MW = MAN_W + 4;   // hidden + fraction + guard/round/sticky
    localparam int EW = EXP_W + 2;   // headroom for carry and overflow detection
    localparam int RW = MAN_W + 2;   // rounded mantissa plus carry-out
    localparam logic [EW-1:0] EXP_MAX    = EW'((1 << EXP_W) - 1);
    localparam logic [EW-1:0] STICKY_ALL = EW'(MAN_W + 3);
    localparam logic [W-1:0]  QNAN       = {1'b0, {EXP_W{1'b1}}, 1'b1, {(MAN_W-1){1'b0}}};
    localparam logic [1:0] RM_RNE = 2'b00;
    localparam logic [1:0] RM_RTZ = 2'b01;
    localparam logic [1:0] RM_RDN = 2'b10;

    typedef enum logic [3:0] {
        IDLE, UNPACK, SPECIAL, ALIGN, ADD, NORM, ROUND, PACK, OUT
    } state_t;

    typedef struct packed {
        logic          sign;
        logic [EW-1:0] expo;
        logic [MW-1:0] mant;
        logic          isNan;
        logic          isSnan;
        logic          isInf;
        logic          isZero;
    } operand_t;

    function automatic operand_t unpackOperand(input logic [W-1:0] word, input logic flipSign);
        operand_t o;
        logic [EXP_W-1:0] e;
        logic [MAN_W-1:0] f;
        e = word[MAN_W +: EXP_W];
        f = word[MAN_W-1:0];
        o.sign   = word[W-1] ^ flipSign;
        o.expo   = (e == '0) ? EW'(1) : {2'b00, e};
        o.mant   = {(e != '0), f, 3'b000};
        o.isZero = (e == '0) && (f == '0);
        o.isInf  = (e == '1) && (f == '0);
        o.isNan  = (e == '1) && (f != '0);
        o.isSnan = o.isNan && !f[MAN_W-1];
        return o;
    endfunction

    function automatic logic [W-1:0] infWord(input logic sign);
        return {sign, {EXP_W{1'b1}}, {MAN_W{1'b0}}};
    endfunction

    function automatic logic [EW-1:0] leadingZeros(input logic [MW-1:0] m);
        logic [EW-1:0] n;
        logic found;
        n = '0;
        found = 1'b0;
        for (int i = MW - 1; i >= 0; i--) begin
            if (!found && !m[i]) n = n + EW'(1);
            else found = 1'b1;
        end
        return n;
    endfunction

    state_t state_q, state_d;
    logic inReady, accept;

    logic [W-1:0] opA_q, opB_q;
    logic         subOp_q;
    logic [1:0]   rm_q;
    operand_t     uA_d, uB_d, uA_q, uB_q;

    logic          isSpecial_d, isSpecial_q;
    logic [W-1:0]  specRes_d, specRes_q;
    logic [2:0]    specFlags_d, specFlags_q;
    logic          bigSign_d, bigSign_q, smallSign_d, smallSign_q;
    logic [EW-1:0] bigExp_d, bigExp_q, smallExp, expDiff_d, expDiff_q;
    logic [MW-1:0] bigMan_d, bigMan_q, smallMan_d, smallMan_q;

    logic [MW-1:0] shifted, lostMask, alignMan_d, alignMan_q;

    logic [MW:0]   sum;
    logic [MW-1:0] addMan_d, addMan_q;
    logic [EW-1:0] addExp_d, addExp_q;
    logic          addZero_d, addZero_q;

    logic [EW-1:0] lzc, normShift, normExp_d, normExp_q;
    logic [MW-1:0] normMan_d, normMan_q;

    logic          roundUp, inexact_d, inexact_q;
    logic [RW-1:0] rounded;
    logic [MAN_W:0] rndMan_d, rndMan_q;
    logic [EW-1:0] rndExp_d, rndExp_q;

    logic          overflow, toInf;
    logic [W-1:0]  outData_d, outData_q;
    logic [2:0]    outFlags_d, outFlags_q;

    assign inReady       = (state_q == IDLE) && !rst;
    assign accept        = bus.in_valid && inReady;
    assign bus.in_ready  = inReady;
    assign bus.out_valid = (state_q == OUT);
    assign bus.out_data  = outData_q;
    assign bus.out_flags = outFlags_q;

    assign uA_d = unpackOperand(opA_q, 1'b0);
    assign uB_d = unpackOperand(opB_q, subOp_q);

    // Stage sequencing: every stage lasts one cycle, OUT waits for the consumer.
    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE:    if (accept) state_d = UNPACK;
            UNPACK:  state_d = SPECIAL;
            SPECIAL: state_d = ALIGN;
            ALIGN:   state_d = ADD;
            ADD:     state_d = NORM;
            NORM:    state_d = ROUND;
            ROUND:   state_d = PACK;
            PACK:    state_d = OUT;
            OUT:     if (bus.out_ready) state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    // State register; reset abandons any operation in flight.
    always_ff @(posedge clk) begin
        if (rst) state_q <= IDLE;
        else     state_q <= state_d;
    end

    // Special-operand result and magnitude ordering so the datapath always subtracts small from big.
    always_comb begin
        isSpecial_d = 1'b1;
        specFlags_d = 3'b000;
        specRes_d   = QNAN;
        if (uA_q.isNan || uB_q.isNan) begin
            specFlags_d[2] = uA_q.isSnan || uB_q.isSnan;
        end else if (uA_q.isInf && uB_q.isInf) begin
            if (uA_q.sign != uB_q.sign) specFlags_d[2] = 1'b1;
            else                        specRes_d = infWord(uA_q.sign);
        end else if (uA_q.isInf) begin
            specRes_d = infWord(uA_q.sign);
        end else if (uB_q.isInf) begin
            specRes_d = infWord(uB_q.sign);
        end else if (uA_q.isZero && uB_q.isZero) begin
            specRes_d = {(uA_q.sign == uB_q.sign) ? uA_q.sign : (rm_q == RM_RDN), {(W-1){1'b0}}};
        end else if (uA_q.isZero) begin
            specRes_d = {uB_q.sign, opB_q[W-2:0]};
        end else if (uB_q.isZero) begin
            specRes_d = opA_q;
        end else begin
            isSpecial_d = 1'b0;
        end

        if ({uA_q.expo, uA_q.mant} >= {uB_q.expo, uB_q.mant}) begin
            bigSign_d   = uA_q.sign;  bigExp_d = uA_q.expo;  bigMan_d   = uA_q.mant;
            smallSign_d = uB_q.sign;  smallExp = uB_q.expo;  smallMan_d = uB_q.mant;
        end else begin
            bigSign_d   = uB_q.sign;  bigExp_d = uB_q.expo;  bigMan_d   = uB_q.mant;
            smallSign_d = uA_q.sign;  smallExp = uA_q.expo;  smallMan_d = uA_q.mant;
        end
        expDiff_d = bigExp_d - smallExp;
    end

    // Align the smaller operand; anything shifted past the sticky bit collapses into it.
    always_comb begin
        shifted  = smallMan_q >> expDiff_q;
        lostMask = ~({MW{1'b1}} << expDiff_q);
        if (expDiff_q >= STICKY_ALL) alignMan_d = {{(MW-1){1'b0}}, |smallMan_q};
        else alignMan_d = shifted | {{(MW-1){1'b0}}, |(smallMan_q & lostMask)};
    end

    // Magnitude add/subtract; a carry-out is folded back with the lost bit kept as sticky.
    always_comb begin
        if (bigSign_q != smallSign_q) sum = {1'b0, bigMan_q} - {1'b0, alignMan_q};
        else                          sum = {1'b0, bigMan_q} + {1'b0, alignMan_q};
        addZero_d = (sum == '0);
        if (sum[MW]) begin
            addMan_d = {sum[MW:2], sum[1] | sum[0]};
            addExp_d = bigExp_q + EW'(1);
        end else begin
            addMan_d = sum[MW-1:0];
            addExp_d = bigExp_q;
        end
    end

    // Normalise left, stopping at the minimum exponent so tiny results stay subnormal.
    always_comb begin
        lzc       = leadingZeros(addMan_q);
        normShift = (lzc < addExp_q - EW'(1)) ? lzc : addExp_q - EW'(1);
        normMan_d = addMan_q << normShift;
        normExp_d = addExp_q - normShift;
    end

    // Round on guard/round/sticky; a mantissa carry bumps the exponent.
    always_comb begin
        inexact_d = |normMan_q[2:0];
        case (rm_q)
            RM_RNE:  roundUp = normMan_q[2] & (normMan_q[1] | normMan_q[0] | normMan_q[3]);
            RM_RTZ:  roundUp = 1'b0;
            RM_RDN:  roundUp = inexact_d & bigSign_q;
            default: roundUp = inexact_d & ~bigSign_q;
        endcase
        rounded = {1'b0, normMan_q[MW-1:3]} + RW'(roundUp);
        if (rounded[RW-1]) begin
            rndMan_d = rounded[RW-1:1];
            rndExp_d = normExp_q + EW'(1);
        end else begin
            rndMan_d = rounded[MAN_W:0];
            rndExp_d = normExp_q;
        end
    end

    // Final word assembly: specials win, then exact zero, then overflow saturation, else the rounded value.
    always_comb begin
        overflow   = (rndExp_q >= EXP_MAX);
        outFlags_d = {2'b00, inexact_q};
        case (rm_q)
            RM_RNE:  toInf = 1'b1;
            RM_RTZ:  toInf = 1'b0;
            RM_RDN:  toInf = bigSign_q;
            default: toInf = ~bigSign_q;
        endcase
        if (isSpecial_q) begin
            outData_d  = specRes_q;
            outFlags_d = specFlags_q;
        end else if (addZero_q) begin
            outData_d  = {(rm_q == RM_RDN), {(W-1){1'b0}}};
            outFlags_d = 3'b000;
        end else if (overflow) begin
            outFlags_d = 3'b011;
            outData_d  = toInf ? infWord(bigSign_q)
                               : {bigSign_q, {(EXP_W-1){1'b1}}, 1'b0, {MAN_W{1'b1}}};
        end else begin
            outData_d = {bigSign_q, rndMan_q[MAN_W] ? rndExp_q[EXP_W-1:0] : {EXP_W{1'b0}},
                         rndMan_q[MAN_W-1:0]};
        end
    end

    // Result registers, captured once per operation and held through OUT.
    always_ff @(posedge clk) begin
        if (rst) begin
            outData_q  <= '0;
            outFlags_q <= '0;
        end else if (state_q == PACK) begin
            outData_q  <= outData_d;
            outFlags_q <= outFlags_d;
        end
    end

    // Datapath stage registers, each loaded only while its stage is active.
    always_ff @(posedge clk) begin
        if (accept) begin
            opA_q   <= bus.in_a;
            opB_q   <= bus.in_b;
            subOp_q <= bus.in_op;
            rm_q    <= bus.in_rm;
        end
        if (state_q == UNPACK) begin
            uA_q <= uA_d;
            uB_q <= uB_d;
        end
        if (state_q == SPECIAL) begin
            isSpecial_q <= isSpecial_d;
            specRes_q   <= specRes_d;
            specFlags_q <= specFlags_d;
            bigSign_q   <= bigSign_d;
            bigExp_q    <= bigExp_d;
            bigMan_q    <= bigMan_d;
            smallSign_q <= smallSign_d;
            smallMan_q  <= smallMan_d;
            expDiff_q   <= expDiff_d;
        end
        if (state_q == ALIGN) alignMan_q <= alignMan_d;
        if (state_q == ADD) begin
            addMan_q  <= addMan_d;
            addExp_q  <= addExp_d;
            addZero_q <= addZero_d;
        end
        if (state_q == NORM) begin
            normMan_q <= normMan_d;
            normExp_q <= normExp_d;
        end
        if (state_q == ROUND) begin
            rndMan_q  <= rndMan_d;
            rndExp_q  <= rndExp_d;
            inexact_q <= inexact_d;
        end
    end
endmodule

// File: tb/tb_fp_addsub_param.sv
// tb_fp_addsub_param: vector table plus handshake/reset/fp16 sequences for fp_addsub_param.
module tb_fp_addsub_param;
    localparam logic [1:0] RNE = 2'b00;
    localparam logic [1:0] RTZ = 2'b01;
    localparam logic [1:0] RDN = 2'b10;
    localparam logic [1:0] RUP = 2'b11;

    logic clk = 1'b0;
    logic rst;
    int   testCount = 0;
    int   failCount = 0;

    always #5 clk = ~clk;

    fp_addsub_param_if #(.W(32)) bus32 ();
    fp_addsub_param_if #(.W(16)) bus16 ();

    fp_addsub_param #(.EXP_W(8), .MAN_W(23)) dut32 (.clk(clk), .rst(rst), .bus(bus32.slave));
    fp_addsub_param #(.EXP_W(5), .MAN_W(10)) dut16 (.clk(clk), .rst(rst), .bus(bus16.slave));

    typedef struct {
        logic [31:0] a;
        logic [31:0] b;
        logic        op;
        logic [1:0]  rm;
        logic [31:0] expData;
        logic [2:0]  expFlags;
        string       name;
    } vector_t;

    typedef struct {
        logic [31:0] data;
        logic [2:0]  flags;
    } expect_t;

    vector_t vectors[$];
    expect_t scoreboard[$];

    task automatic compare(input string name, input logic [31:0] actual, input logic [31:0] required);
        testCount++;
        if (actual !== required) begin
            failCount++;
            $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", name, actual, required);
        end
    endtask

    function automatic void addVec(input logic [31:0] a, input logic [31:0] b, input logic op,
                                   input logic [1:0] rm, input logic [31:0] d, input logic [2:0] f,
                                   input string name);
        vector_t v;
        v.a = a; v.b = b; v.op = op; v.rm = rm; v.expData = d; v.expFlags = f; v.name = name;
        vectors.push_back(v);
    endfunction

    task automatic pushExpect(input logic [31:0] d, input logic [2:0] f);
        expect_t e;
        e.data = d;
        e.flags = f;
        scoreboard.push_back(e);
    endtask

    task automatic applyStimulus(input logic [31:0] a, input logic [31:0] b, input logic op,
                                 input logic [1:0] rm, input logic [31:0] expData,
                                 input logic [2:0] expFlags, input string name);
        int waited = 0;
        @(negedge clk);
        while (bus32.in_ready !== 1'b1 && waited < 50) begin
            @(negedge clk);
            waited++;
        end
        compare({name, " in_ready"}, 32'(bus32.in_ready), 32'd1);
        bus32.in_a = a; bus32.in_b = b; bus32.in_op = op; bus32.in_rm = rm;
        bus32.in_valid = 1'b1;
        pushExpect(expData, expFlags);
        @(posedge clk);
        #1;
        bus32.in_valid = 1'b0;
    endtask

    task automatic checkOutput(input string name, input int holdCycles);
        int latency = 0;
        expect_t e;
        while (bus32.out_valid !== 1'b1 && latency < 30) begin
            @(posedge clk);
            #1;
            latency++;
        end
        compare({name, " latency"}, 32'(latency), 32'd7);
        if (scoreboard.size() == 0) begin
            testCount++;
            failCount++;
            $display("[TB] FAIL %s scoreboard: got output, expected nothing pending", name);
            return;
        end
        e = scoreboard.pop_front();
        compare({name, " data"}, bus32.out_data, e.data);
        compare({name, " flags"}, 32'(bus32.out_flags), 32'(e.flags));
        for (int i = 0; i < holdCycles; i++) begin
            bus32.in_a = 32'h12345678; bus32.in_b = 32'h9ABCDEF0; bus32.in_valid = 1'b1;
            @(posedge clk);
            #1;
            compare({name, " hold data"}, bus32.out_data, e.data);
            compare({name, " hold valid/ready"}, {30'd0, bus32.out_valid, bus32.in_ready}, 32'b10);
        end
        bus32.in_valid = 1'b0;
        bus32.out_ready = 1'b1;
        @(posedge clk);
        #1;
        bus32.out_ready = 1'b0;
        compare({name, " release"}, {30'd0, bus32.out_valid, bus32.in_ready}, 32'b01);
    endtask

    task automatic runHalf(input logic [15:0] a, input logic [15:0] b, input logic op,
                           input logic [1:0] rm, input logic [15:0] expData,
                           input logic [2:0] expFlags, input string name);
        int waited = 0;
        int latency = 0;
        expect_t e;
        @(negedge clk);
        while (bus16.in_ready !== 1'b1 && waited < 50) begin
            @(negedge clk);
            waited++;
        end
        compare({name, " in_ready"}, 32'(bus16.in_ready), 32'd1);
        bus16.in_a = a; bus16.in_b = b; bus16.in_op = op; bus16.in_rm = rm;
        bus16.in_valid = 1'b1;
        pushExpect({16'd0, expData}, expFlags);
        @(posedge clk);
        #1;
        bus16.in_valid = 1'b0;
        while (bus16.out_valid !== 1'b1 && latency < 30) begin
            @(posedge clk);
            #1;
            latency++;
        end
        compare({name, " latency"}, 32'(latency), 32'd7);
        e = scoreboard.pop_front();
        compare({name, " data"}, {16'd0, bus16.out_data}, e.data);
        compare({name, " flags"}, 32'(bus16.out_flags), 32'(e.flags));
        bus16.out_ready = 1'b1;
        @(posedge clk);
        #1;
        bus16.out_ready = 1'b0;
    endtask

    // Global time limit so a stuck handshake still ends the run.
    initial begin
        #400000;
        $display("[TB] FAIL watchdog: simulation time limit reached");
        $fatal(1, "[TB] watchdog expired");
    end

    // Main test sequence.
    initial begin
        logic sawValid;

        addVec(32'h3F800000, 32'h40000000, 1'b0, RNE, 32'h40400000, 3'b000, "1+2");
        addVec(32'h3F800000, 32'h3F800000, 1'b1, RNE, 32'h00000000, 3'b000, "1-1 rne");
        addVec(32'h3F800000, 32'h3F800000, 1'b1, RDN, 32'h80000000, 3'b000, "1-1 rdn");
        addVec(32'h7F800000, 32'h7F800000, 1'b1, RNE, 32'h7FC00000, 3'b100, "inf-inf");
        addVec(32'h7FA00000, 32'h3F800000, 1'b0, RNE, 32'h7FC00000, 3'b100, "snan");
        addVec(32'h7FC00000, 32'h3F800000, 1'b0, RNE, 32'h7FC00000, 3'b000, "qnan");
        addVec(32'h7F800000, 32'h3F800000, 1'b0, RNE, 32'h7F800000, 3'b000, "inf+1");
        addVec(32'h3F800000, 32'h7F800000, 1'b1, RNE, 32'hFF800000, 3'b000, "1-inf");
        addVec(32'h7F7FFFFF, 32'h7F7FFFFF, 1'b0, RNE, 32'h7F800000, 3'b011, "ovf rne");
        addVec(32'h7F7FFFFF, 32'h7F7FFFFF, 1'b0, RTZ, 32'h7F7FFFFF, 3'b011, "ovf rtz");
        addVec(32'h7F7FFFFF, 32'h7F7FFFFF, 1'b0, RUP, 32'h7F800000, 3'b011, "ovf rup");
        addVec(32'h7F7FFFFF, 32'h7F7FFFFF, 1'b0, RDN, 32'h7F7FFFFF, 3'b011, "ovf rdn");
        addVec(32'hFF7FFFFF, 32'hFF7FFFFF, 1'b0, RDN, 32'hFF800000, 3'b011, "novf rdn");
        addVec(32'hFF7FFFFF, 32'hFF7FFFFF, 1'b0, RUP, 32'hFF7FFFFF, 3'b011, "novf rup");
        addVec(32'h3F800000, 32'h33800000, 1'b0, RNE, 32'h3F800000, 3'b001, "tie even");
        addVec(32'h3F800000, 32'h33800000, 1'b0, RUP, 32'h3F800001, 3'b001, "tie rup");
        addVec(32'h3F800000, 32'h34400000, 1'b0, RNE, 32'h3F800002, 3'b001, "tie odd");
        addVec(32'h3F800000, 32'h34400000, 1'b0, RTZ, 32'h3F800001, 3'b001, "odd rtz");
        addVec(32'hBF800000, 32'hB3800000, 1'b0, RDN, 32'hBF800001, 3'b001, "neg rdn");
        addVec(32'hBF800000, 32'hB3800000, 1'b0, RUP, 32'hBF800000, 3'b001, "neg rup");
        addVec(32'h3F800000, 32'h33800000, 1'b1, RNE, 32'h3F7FFFFF, 3'b000, "1-ulp");
        addVec(32'h3F800000, 32'h00000001, 1'b0, RUP, 32'h3F800001, 3'b001, "far rup");
        addVec(32'h3F800000, 32'h00000001, 1'b0, RNE, 32'h3F800000, 3'b001, "far rne");
        addVec(32'h00000001, 32'h00000001, 1'b0, RNE, 32'h00000002, 3'b000, "sub+sub");
        addVec(32'h00400000, 32'h00400000, 1'b0, RNE, 32'h00800000, 3'b000, "sub->norm");
        addVec(32'h00800000, 32'h00000001, 1'b1, RNE, 32'h007FFFFF, 3'b000, "norm->sub");
        addVec(32'h00000000, 32'h3F800000, 1'b1, RNE, 32'hBF800000, 3'b000, "0-1");
        addVec(32'h80000000, 32'h80000000, 1'b0, RNE, 32'h80000000, 3'b000, "-0+-0");
        addVec(32'h00000000, 32'h80000000, 1'b0, RNE, 32'h00000000, 3'b000, "+0+-0 rne");
        addVec(32'h00000000, 32'h80000000, 1'b0, RDN, 32'h80000000, 3'b000, "+0+-0 rdn");

        rst = 1'b1;
        bus32.in_a = '0; bus32.in_b = '0; bus32.in_op = 1'b0; bus32.in_rm = RNE;
        bus32.in_valid = 1'b0; bus32.out_ready = 1'b0;
        bus16.in_a = '0; bus16.in_b = '0; bus16.in_op = 1'b0; bus16.in_rm = RNE;
        bus16.in_valid = 1'b0; bus16.out_ready = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        compare("reset in_ready", 32'(bus32.in_ready), 32'd0);
        compare("reset out_valid", 32'(bus32.out_valid), 32'd0);
        compare("reset out_data", bus32.out_data, 32'd0);
        compare("reset out_flags", 32'(bus32.out_flags), 32'd0);
        @(negedge clk);
        rst = 1'b0;
        #1;
        compare("in_ready after reset", 32'(bus32.in_ready), 32'd1);

        foreach (vectors[i]) begin
            applyStimulus(vectors[i].a, vectors[i].b, vectors[i].op, vectors[i].rm,
                          vectors[i].expData, vectors[i].expFlags, vectors[i].name);
            checkOutput(vectors[i].name, 0);
        end

        applyStimulus(32'h3F800000, 32'h40000000, 1'b0, RNE, 32'h40400000, 3'b000, "backpressure");
        checkOutput("backpressure", 5);
        applyStimulus(32'h40000000, 32'h3F800000, 1'b1, RNE, 32'h3F800000, 3'b000, "after hold");
        checkOutput("after hold", 0);

        @(negedge clk);
        bus32.in_a = 32'h3F800000; bus32.in_b = 32'h40000000; bus32.in_op = 1'b0; bus32.in_rm = RNE;
        bus32.in_valid = 1'b1;
        @(posedge clk);
        #1;
        bus32.in_valid = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        rst = 1'b1;
        @(posedge clk);
        #1;
        compare("abort in_ready during rst", 32'(bus32.in_ready), 32'd0);
        rst = 1'b0;
        #1;
        compare("abort in_ready after rst", 32'(bus32.in_ready), 32'd1);
        sawValid = 1'b0;
        repeat (12) begin
            @(posedge clk);
            #1;
            if (bus32.out_valid !== 1'b0) sawValid = 1'b1;
        end
        compare("abort no output", 32'(sawValid), 32'd0);
        applyStimulus(32'h40000000, 32'h40000000, 1'b0, RNE, 32'h40800000, 3'b000, "recovery");
        checkOutput("recovery", 0);

        runHalf(16'h3C00, 16'h3C00, 1'b0, RNE, 16'h4000, 3'b000, "h 1+1");
        runHalf(16'h3C00, 16'h3C00, 1'b1, RDN, 16'h8000, 3'b000, "h 1-1 rdn");
        runHalf(16'h7BFF, 16'h7BFF, 1'b0, RNE, 16'h7C00, 3'b011, "h ovf");
        runHalf(16'h7C00, 16'h7C00, 1'b1, RNE, 16'h7E00, 3'b100, "h inf-inf");

        $display("[TB] %0d tests run, %0d failed", testCount, failCount);
        $finish;
    end
endmodule
